aq_vpu_fmau_wb_ctrl: RTL and testbench
======================================

Name: aq_vpu_fmau_wb_ctrl

Overview:
- VPU-side consumer of the vector FMA unit result interface.
- Captures completions from the three FMAU exit stages: ex3 for special/early results, ex4 for single/half, ex5 for double/MAC.
- Queues each completion in arrival order, with oldest stage first when several arrive in one cycle. Drains one entry per cycle to the vector register-file write port under a valid/grant handshake.
- Accumulates sticky IEEE fflags for CP0 and back-pressures the FMAU pipeline through a stall output.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 4.
- PTR_W, 2, pointer width, log2(DEPTH).

Ports:
- forever_cpuclk  in  1  core clock
- cpurst_b  in  1  async active-low reset
- vfmau_vpu_ex3_vld  in  1  ex3 completion valid
- vfmau_vpu_ex3_fpr_result  in  64  ex3 result
- vfmau_vpu_ex3_fflags  in  5  ex3 flags {NV,DZ,OF,UF,NX}
- vfmau_vpu_ex3_vreg  in  5  ex3 destination register
- vfmau_vpu_ex4_vld / _fpr_result / _fflags / _vreg  in  1/64/5/5  ex4 completion
- vfmau_vpu_ex5_vld / _fpr_result / _fflags / _vreg  in  1/64/5/5  ex5 completion
- rtu_vpu_flush  in  1  pipeline flush
- cp0_vpu_fflags_clr  in  1  clear sticky flags
- vrf_vpu_wb_grant  in  1  register file accepts the write
- vpu_vrf_wb_vld  out  1  write request
- vpu_vrf_wb_data  out  64  write data
- vpu_vrf_wb_vreg  out  5  write destination
- vpu_cp0_fflags  out  5  sticky accumulated flags
- vpu_fmau_stall  out  1  hold FMAU pipeline
- vpu_fmau_wb_empty  out  1  FIFO empty, nothing in flight

Behaviour:
- Reset (cpurst_b low, asynchronous):
  - read pointer, write pointer and count cleared to 0.
  - vpu_vrf_wb_vld=0, vpu_vrf_wb_data=0, vpu_vrf_wb_vreg=0.
  - vpu_cp0_fflags=0, vpu_fmau_stall=0, vpu_fmau_wb_empty=1.
  - Reset mid-operation discards all entries; no write issued after release until a new completion arrives.
- Push:
  - up to 3 pushes per cycle.
  - order: ex5 first, then ex4, then ex3, compacted into consecutive slots at wrptr, wrptr+1, wrptr+2.
  - pointers wrap modulo DEPTH.
  - entry = {result, vreg, fflags}.
- Pop:
  - head is presented on vpu_vrf_wb_* (registered head, no combinational input-to-output path).
  - pop when vpu_vrf_wb_vld && vrf_vpu_wb_grant.
  - vld holds and data stays stable until grant.
  - grant with vld=0 is ignored.
- Latency: a completion pushed in cycle N into an empty FIFO drives wb_vld in cycle N+1.
- Count: count_next = count + pushes − pop. Simultaneous push and pop on a full FIFO is legal because of the stall guarantee.
- Stall: vpu_fmau_stall is registered, =1 when count_next > DEPTH−3 (fewer than 3 free slots). The FMAU must not assert any *_vld while stall=1.
- Overflow: a push while free slots < pushes is a protocol violation. Flagged by an assertion only; hardware drops the excess entries.
- Empty flag: vpu_fmau_wb_empty = (count==0).
- Flush:
  - rtu_vpu_flush clears pointers and count in that cycle and wins over same-cycle pushes and pop.
  - wb_vld=0 in the next cycle; fflags are not modified.
- Fflags accumulation:
  - on pop, vpu_cp0_fflags |= head fflags.
  - clear and pop in the same cycle: result = head fflags only (clear first, then OR).
  - clear alone: 0 next cycle.
- Ordering: entries retire strictly in FIFO order; the same vreg may appear multiple times.

Optional Feature:
- Macro: AQ_VPU_WB_BYPASS_EN.
- Defined:
  - when count==0 and no entry is held, the oldest same-cycle completion (ex5>ex4>ex3) is driven combinationally onto vpu_vrf_wb_* in cycle N.
  - if granted, it is not enqueued; remaining completions enqueue normally.
  - fflags still accumulate on that grant.
- Undefined: always registered, 1-cycle minimum latency, as described above.

Test Plan:
- Single ex4 completion, result=64'h3FF0_0000_0000_0000, vreg=5, fflags=5'b00001, grant held 1 -> wb_vld one cycle later with the same data and vreg; vpu_cp0_fflags=5'b00001 after the grant.
- Same cycle: ex5 (vreg=1), ex4 (vreg=2), ex3 (vreg=3), grant=1 -> writes retire in order vreg 1,2,3 on consecutive cycles; count peaks at 3; stall asserts when count_next>1 (DEPTH=4).
- Grant held 0 for 6 cycles with completions 1/cycle until stall -> stall=1 once fewer than 3 slots are free; wb_data stays stable; no entry lost; drains in order after grant=1.
- Flush with 3 entries queued plus a same-cycle ex3 push -> next cycle wb_vld=0, wb_empty=1; fflags unchanged.
- fflags=5'b10000 popped in the same cycle as cp0_vpu_fflags_clr with prior fflags=5'b00011 -> vpu_cp0_fflags=5'b10000.
- Reset asserted with 2 entries queued and wb_vld=1 -> all outputs at reset values immediately; after release no write until a new completion arrives.

Source files
------------

// File: rtl/aq_vpu_fmau_wb_ctrl.sv
// Write-back controller for the vector FMA unit: collects ex3/ex4/ex5 completions, retires them in order to the VRF.
// Optional same-cycle bypass into an empty queue is enabled by defining AQ_VPU_WB_BYPASS_EN.
module aq_vpu_fmau_wb_ctrl #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        vfmau_vpu_ex3_vld,
   input  logic [63:0] vfmau_vpu_ex3_fpr_result,
   input  logic [4:0]  vfmau_vpu_ex3_fflags,
   input  logic [4:0]  vfmau_vpu_ex3_vreg,
   input  logic        vfmau_vpu_ex4_vld,
   input  logic [63:0] vfmau_vpu_ex4_fpr_result,
   input  logic [4:0]  vfmau_vpu_ex4_fflags,
   input  logic [4:0]  vfmau_vpu_ex4_vreg,
   input  logic        vfmau_vpu_ex5_vld,
   input  logic [63:0] vfmau_vpu_ex5_fpr_result,
   input  logic [4:0]  vfmau_vpu_ex5_fflags,
   input  logic [4:0]  vfmau_vpu_ex5_vreg,
   input  logic        rtu_vpu_flush,
   input  logic        cp0_vpu_fflags_clr,
   input  logic        vrf_vpu_wb_grant,
   output logic        vpu_vrf_wb_vld,
   output logic [63:0] vpu_vrf_wb_data,
   output logic [4:0]  vpu_vrf_wb_vreg,
   output logic [4:0]  vpu_cp0_fflags,
   output logic        vpu_fmau_stall,
   output logic        vpu_fmau_wb_empty
);

   localparam int CW = PTR_W + 1;

   typedef struct packed {
      logic [63:0] data;
      logic [4:0]  vreg;
      logic [4:0]  ff;
   } ent_t;

   ent_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_rdptr;
   logic [PTR_W-1:0] r_wrptr;
   logic [CW-1:0]    r_count;
   logic             r_stall;
   logic [4:0]       r_fflags;

   ent_t             w_ent [4];
   logic [1:0]       w_n;
   ent_t             w_qent [3];
   logic [1:0]       w_qn;
   ent_t             w_head;
   logic             w_fifo_vld;
   logic             w_byp;
   logic             w_pop;
   logic             w_take;
   logic [CW-1:0]    w_free;
   logic [CW-1:0]    w_acc;
   logic [CW-1:0]    w_cnt_nxt;
   logic [4:0]       w_ff_add;
   logic [4:0]       w_ff_nxt;

   // Compact the same-cycle completions oldest stage first.
   always_comb begin
      w_n = 2'd0;
      for (int k = 0; k < 4; k++) w_ent[k] = '0;
      if (vfmau_vpu_ex5_vld) begin
         w_ent[w_n] = '{vfmau_vpu_ex5_fpr_result, vfmau_vpu_ex5_vreg, vfmau_vpu_ex5_fflags};
         w_n = w_n + 2'd1;
      end
      if (vfmau_vpu_ex4_vld) begin
         w_ent[w_n] = '{vfmau_vpu_ex4_fpr_result, vfmau_vpu_ex4_vreg, vfmau_vpu_ex4_fflags};
         w_n = w_n + 2'd1;
      end
      if (vfmau_vpu_ex3_vld) begin
         w_ent[w_n] = '{vfmau_vpu_ex3_fpr_result, vfmau_vpu_ex3_vreg, vfmau_vpu_ex3_fflags};
         w_n = w_n + 2'd1;
      end
   end

`ifdef AQ_VPU_WB_BYPASS_EN
   assign w_byp = (r_count == '0) && (w_n != 2'd0) && !rtu_vpu_flush;
`else
   assign w_byp = 1'b0;
`endif

   assign w_fifo_vld = (r_count != '0);
   assign w_head     = w_fifo_vld ? r_mem[r_rdptr] : (w_byp ? w_ent[0] : '0);
   assign w_pop      = w_fifo_vld && vrf_vpu_wb_grant && !rtu_vpu_flush;
   assign w_take     = w_byp && vrf_vpu_wb_grant;

   // A bypassed completion is consumed directly and must not also be queued.
   always_comb begin
      for (int k = 0; k < 3; k++) w_qent[k] = w_take ? w_ent[k+1] : w_ent[k];
      w_qn = w_n - {1'b0, w_take};
   end

   assign w_free    = CW'(DEPTH) - r_count + CW'(w_pop);
   assign w_acc     = (CW'(w_qn) > w_free) ? w_free : CW'(w_qn);
   assign w_cnt_nxt = r_count + w_acc - CW'(w_pop);

   assign w_ff_add = (w_pop || w_take) ? w_head.ff : 5'd0;
   assign w_ff_nxt = cp0_vpu_fflags_clr ? w_ff_add : (r_fflags | w_ff_add);

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_rdptr  <= '0;
         r_wrptr  <= '0;
         r_count  <= '0;
         r_stall  <= 1'b0;
         r_fflags <= 5'd0;
      end else if (rtu_vpu_flush) begin
         r_rdptr  <= '0;
         r_wrptr  <= '0;
         r_count  <= '0;
         r_stall  <= 1'b0;
         if (cp0_vpu_fflags_clr) r_fflags <= 5'd0;
      end else begin
         r_rdptr  <= r_rdptr + PTR_W'(w_pop);
         r_wrptr  <= r_wrptr + PTR_W'(w_acc);
         r_count  <= w_cnt_nxt;
         r_stall  <= (w_cnt_nxt > CW'(DEPTH - 3));
         r_fflags <= w_ff_nxt;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge forever_cpuclk) begin
      if (!rtu_vpu_flush) begin
         for (int k = 0; k < 3; k++) begin
            if (CW'(k) < w_acc) r_mem[PTR_W'(r_wrptr + PTR_W'(k))] <= w_qent[k];
         end
      end
   end

   // Pushing more completions than free slots means the FMAU ignored stall.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst_b && !rtu_vpu_flush) assert (CW'(w_qn) <= w_free);
   end

   assign vpu_vrf_wb_vld    = w_fifo_vld || w_byp;
   assign vpu_vrf_wb_data   = w_head.data;
   assign vpu_vrf_wb_vreg   = w_head.vreg;
   assign vpu_cp0_fflags    = r_fflags;
   assign vpu_fmau_stall    = r_stall;
   assign vpu_fmau_wb_empty = (r_count == '0);

endmodule

// File: tb/tb_aq_vpu_fmau_wb_ctrl.sv
// Directed plus randomized bench for aq_vpu_fmau_wb_ctrl against a queue-based reference model.
module tb_aq_vpu_fmau_wb_ctrl;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        ex3_vld, ex4_vld, ex5_vld;
   logic [63:0] ex3_res, ex4_res, ex5_res;
   logic [4:0]  ex3_ff, ex4_ff, ex5_ff;
   logic [4:0]  ex3_vr, ex4_vr, ex5_vr;
   logic        flush, fclr, grant;
   logic        wb_vld;
   logic [63:0] wb_data;
   logic [4:0]  wb_vreg;
   logic [4:0]  cp0_ff;
   logic        stall, empty;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] d;
      logic [4:0]  v;
      logic [4:0]  f;
   } ent_t;

   ent_t       q[$];
   logic [4:0] m_flags;
   logic       m_stall;

   always #5 clk = ~clk;

   aq_vpu_fmau_wb_ctrl #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .forever_cpuclk           (clk),
      .cpurst_b                 (rst_b),
      .vfmau_vpu_ex3_vld        (ex3_vld),
      .vfmau_vpu_ex3_fpr_result (ex3_res),
      .vfmau_vpu_ex3_fflags     (ex3_ff),
      .vfmau_vpu_ex3_vreg       (ex3_vr),
      .vfmau_vpu_ex4_vld        (ex4_vld),
      .vfmau_vpu_ex4_fpr_result (ex4_res),
      .vfmau_vpu_ex4_fflags     (ex4_ff),
      .vfmau_vpu_ex4_vreg       (ex4_vr),
      .vfmau_vpu_ex5_vld        (ex5_vld),
      .vfmau_vpu_ex5_fpr_result (ex5_res),
      .vfmau_vpu_ex5_fflags     (ex5_ff),
      .vfmau_vpu_ex5_vreg       (ex5_vr),
      .rtu_vpu_flush            (flush),
      .cp0_vpu_fflags_clr       (fclr),
      .vrf_vpu_wb_grant         (grant),
      .vpu_vrf_wb_vld           (wb_vld),
      .vpu_vrf_wb_data          (wb_data),
      .vpu_vrf_wb_vreg          (wb_vreg),
      .vpu_cp0_fflags           (cp0_ff),
      .vpu_fmau_stall           (stall),
      .vpu_fmau_wb_empty        (empty)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [63:0] ed;
      logic [4:0]  ev;
      ed = 64'd0;
      ev = 5'd0;
      if (q.size() != 0) begin
         ed = q[0].d;
         ev = q[0].v;
      end
      chk("wb_vld",   {63'd0, wb_vld}, {63'd0, q.size() != 0});
      chk("wb_data",  wb_data, ed);
      chk("wb_vreg",  {59'd0, wb_vreg}, {59'd0, ev});
      chk("fflags",   {59'd0, cp0_ff}, {59'd0, m_flags});
      chk("stall",    {63'd0, stall}, {63'd0, m_stall});
      chk("empty",    {63'd0, empty}, {63'd0, q.size() == 0});
   endtask

   task automatic model_reset();
      q.delete();
      m_flags = 5'd0;
      m_stall = 1'b0;
   endtask

   // Reference behaviour for one clock edge, from the current inputs.
   task automatic model_update();
      logic [4:0] hf;
      hf = 5'd0;
      if (flush) begin
         q.delete();
         if (fclr) m_flags = 5'd0;
      end else begin
         if (q.size() != 0 && grant) begin
            hf = q[0].f;
            void'(q.pop_front());
         end
         if (ex5_vld) q.push_back('{ex5_res, ex5_vr, ex5_ff});
         if (ex4_vld) q.push_back('{ex4_res, ex4_vr, ex4_ff});
         if (ex3_vld) q.push_back('{ex3_res, ex3_vr, ex3_ff});
         m_flags = fclr ? hf : (m_flags | hf);
      end
      m_stall = (q.size() > DEPTH - 3);
   endtask

   task automatic step();
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex3_vld = 1'b0; ex4_vld = 1'b0; ex5_vld = 1'b0;
      flush = 1'b0; fclr = 1'b0;
   endtask

   task automatic rnd_ent(output logic [63:0] d, output logic [4:0] v, output logic [4:0] f);
      d = {$urandom, $urandom};
      v = 5'($urandom_range(0, 31));
      f = 5'($urandom_range(0, 31));
   endtask

   initial begin
      rst_b = 1'b0;
      grant = 1'b0;
      idle();
      ex3_res = '0; ex4_res = '0; ex5_res = '0;
      ex3_ff = '0; ex4_ff = '0; ex5_ff = '0;
      ex3_vr = '0; ex4_vr = '0; ex5_vr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst_b = 1'b1;
      step();

      // single ex4 completion, one-cycle latency, flags after grant
      grant = 1'b1;
      ex4_vld = 1'b1; ex4_res = 64'h3FF0_0000_0000_0000; ex4_vr = 5'd5; ex4_ff = 5'b00001;
      step();
      idle();
      repeat (3) step();

      // three completions in one cycle retire ex5, ex4, ex3
      ex5_vld = 1'b1; ex5_vr = 5'd1; ex5_res = 64'h1111; ex5_ff = 5'b00100;
      ex4_vld = 1'b1; ex4_vr = 5'd2; ex4_res = 64'h2222; ex4_ff = 5'b00010;
      ex3_vld = 1'b1; ex3_vr = 5'd3; ex3_res = 64'h3333; ex3_ff = 5'b01000;
      step();
      idle();
      repeat (5) step();

      // back-pressure: no grant, one completion per cycle while stall allows
      grant = 1'b0;
      for (int i = 0; i < 6; i++) begin
         idle();
         if (!m_stall) begin
            ex3_vld = 1'b1;
            rnd_ent(ex3_res, ex3_vr, ex3_ff);
         end
         step();
      end
      idle();
      grant = 1'b1;
      repeat (5) step();

      // flush with three queued entries and a same-cycle ex3 push
      grant = 1'b0;
      ex5_vld = 1'b1; rnd_ent(ex5_res, ex5_vr, ex5_ff);
      ex4_vld = 1'b1; rnd_ent(ex4_res, ex4_vr, ex4_ff);
      ex3_vld = 1'b1; rnd_ent(ex3_res, ex3_vr, ex3_ff);
      step();
      idle();
      flush = 1'b1;
      ex3_vld = 1'b1; rnd_ent(ex3_res, ex3_vr, ex3_ff);
      step();
      idle();
      step();

      // clear concurrent with pop keeps only the popped flags
      fclr = 1'b1;
      step();
      idle();
      grant = 1'b1;
      ex4_vld = 1'b1; ex4_res = 64'hA; ex4_vr = 5'd7; ex4_ff = 5'b00011;
      step();
      idle();
      step();
      ex4_vld = 1'b1; ex4_res = 64'hB; ex4_vr = 5'd8; ex4_ff = 5'b10000;
      step();
      idle();
      fclr = 1'b1;
      step();
      idle();
      step();

      // reset mid-operation with two entries queued
      grant = 1'b0;
      ex5_vld = 1'b1; rnd_ent(ex5_res, ex5_vr, ex5_ff);
      ex4_vld = 1'b1; rnd_ent(ex4_res, ex4_vr, ex4_ff);
      step();
      idle();
      step();
      rst_b = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      grant = 1'b1;
      repeat (3) step();

      // randomized traffic honouring stall
      for (int i = 0; i < 600; i++) begin
         idle();
         grant = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 24) == 0);
         fclr  = ($urandom_range(0, 9) == 0);
         if (!m_stall) begin
            ex5_vld = $urandom_range(0, 1) == 1;
            ex4_vld = $urandom_range(0, 1) == 1;
            ex3_vld = $urandom_range(0, 1) == 1;
         end
         rnd_ent(ex5_res, ex5_vr, ex5_ff);
         rnd_ent(ex4_res, ex4_vr, ex4_ff);
         rnd_ent(ex3_res, ex3_vr, ex3_ff);
         step();
      end
      idle();
      grant = 1'b1;
      repeat (5) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
